data_memory_responder: RTL and testbench

- Responder end of the CPU's MEM-stage data-memory interface. The pipeline initiates loads and stores; this block services them with a fixed multi-cycle latency.
- It holds the pipeline via stall_o while an access is in flight, then returns read data with a one-cycle ack_o.
- It sits between the EX/MEM pipeline register outputs and the MEM/WB register inputs.
- It replaces the zero-latency combinational data memory.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/data_mem_array.sv | 37 +++
 rtl/data_memory_responder.sv | 117 +++++++++++
 tb/tb_data_memory_responder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int WORD_W              = 32;
    localparam int DEFAULT_DEPTH_WORDS = 256;
    localparam int DEFAULT_LATENCY     = 4;
    // Wide enough for the largest legal LATENCY-1 (14).
    localparam int CNT_W               = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, used for the word-index width.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port word array: synchronous write, registered read.
// Latency: write lands at the edge with we high; rdata updates at the edge with re high.
// Backpressure: none; rdata holds its value when re is low.
module data_mem_array
    import cpu_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    localparam int IDX_W      = clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    // Storage is deliberately not reset so the array can map onto an SRAM macro.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    // Read port register; cleared on reset, otherwise holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// MEM-stage data-memory responder: services one load/store with a fixed multi-cycle latency.
// Latency: stall_o high for LATENCY+1 cycles from the accept cycle, then a one-cycle ack_o.
// Backpressure: stall_o holds the pipeline; inputs are ignored after accept until the cycle after ack_o.
module data_memory_responder
    import cpu_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int LATENCY     = DEFAULT_LATENCY
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [31:0]       addr_i,
    input  logic [WORD_W-1:0] data_i,
    output logic [WORD_W-1:0] data_o,
    output logic              stall_o,
    output logic              ack_o
);

    localparam int               IDX_W    = clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              req;
    logic              accept;
    logic              commit;
    logic              op_write;
    logic              op_read;
    logic [IDX_W-1:0]  idx_q;
    logic [WORD_W-1:0] wdata_q;

    // Byte-offset bits and bits above the index are intentionally dropped.
    logic unused_addr;
    assign unused_addr = ^{addr_i[31:IDX_W+2], addr_i[1:0]};

    // Gating with reset keeps stall_o low while reset is asserted, even with a request present.
    assign req = rst_i & (MemRead_i | MemWrite_i);

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        stall_o   = 1'b0;
        ack_o     = 1'b0;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    stall_o   = 1'b1;
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (cnt == '0) begin
                    commit    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // The request still on the inputs is the one just serviced; never re-accept here.
                ack_o     = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register and latency counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= CNT_LOAD;
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Latched copy of the request; a simultaneous read+write is serviced as a write.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_write <= 1'b0;
            op_read  <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
        end else if (accept) begin
            op_write <= MemWrite_i;
            op_read  <= MemRead_i & ~MemWrite_i;
            idx_q    <= addr_i[IDX_W+1:2];
            wdata_q  <= data_i;
        end
    end

    data_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk_i),
        .rst_n (rst_i),
        .we    (commit & op_write),
        .re    (commit & op_read),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (data_o)
    );

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder (LATENCY=4 and LATENCY=1 instances).
// Expected ack cycle and data are queued at accept time and compared when ack_o pulses.
// Stall is checked cycle by cycle inside each access.
module tb_data_memory_responder;

    localparam int LAT0 = 4;
    localparam int LAT1 = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd, wr, rd1, wr1;
    logic [31:0] addr, wdat, rdat, addr1, wdat1, rdat1;
    logic        stall, ack, stall1, ack1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int          cyc;
        logic [31:0] dat;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] mdl [int];
    logic [31:0] last [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(LAT0)) u_dut (
        .clk_i(clk), .rst_i(rst_n), .MemRead_i(rd), .MemWrite_i(wr),
        .addr_i(addr), .data_i(wdat), .data_o(rdat), .stall_o(stall), .ack_o(ack)
    );

    data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(LAT1)) u_dut1 (
        .clk_i(clk), .rst_i(rst_n), .MemRead_i(rd1), .MemWrite_i(wr1),
        .addr_i(addr1), .data_i(wdat1), .data_o(rdat1), .stall_o(stall1), .ack_o(ack1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic drive(input int sel, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            rd = r; wr = w; addr = a; wdat = d;
        end else begin
            rd1 = r; wr1 = w; addr1 = a; wdat1 = d;
        end
    endtask

    // Scoreboard for the LATENCY=4 instance.
    always @(negedge clk) begin
        exp_t e;
        if (ack) begin
            check("ack_stall_excl0", {31'd0, stall}, 32'd0);
            if (q0.size() == 0) begin
                check("spurious_ack0", {31'd0, ack}, 32'd0);
            end else begin
                e = q0.pop_front();
                check("ack_cycle0", cyc, e.cyc);
                check("ack_data0", rdat, e.dat);
            end
        end
    end

    // Scoreboard for the LATENCY=1 instance.
    always @(negedge clk) begin
        exp_t e;
        if (ack1) begin
            check("ack_stall_excl1", {31'd0, stall1}, 32'd0);
            if (q1.size() == 0) begin
                check("spurious_ack1", {31'd0, ack1}, 32'd0);
            end else begin
                e = q1.pop_front();
                check("ack_cycle1", cyc, e.cyc);
                check("ack_data1", rdat1, e.dat);
            end
        end
    end

    // Starts just after a rising edge. Request stays on the inputs through DONE;
    // drop clears it in cycle C+1, keep leaves it asserted on return.
    task automatic access(input int sel, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          input bit drop, input bit keep);
        int   lat;
        int   c;
        int   key;
        exp_t e;
        lat = (sel == 0) ? LAT0 : LAT1;
        key = sel * 256 + int'((a >> 2) & 32'hFF);
        drive(sel, r, w, a, d);
        c = cyc;
        if (w) mdl[key] = d;
        else   last[sel] = mdl[key];
        e.cyc = c + lat + 1;
        e.dat = last[sel];
        if (sel == 0) q0.push_back(e);
        else          q1.push_back(e);
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d_c%0d", sel, k), {31'd0, (sel == 0) ? stall : stall1}, 32'd1);
            @(posedge clk); #1;
            if (drop && k == 0) drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        @(negedge clk);
        check($sformatf("stall%0d_done", sel), {31'd0, (sel == 0) ? stall : stall1}, 32'd0);
        @(posedge clk); #1;
        if (!keep) drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        last[0] = 32'h0;
        last[1] = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_stall", {31'd0, stall}, 32'd0);
            check("idle_ack",   {31'd0, ack},   32'd0);
            check("idle_data",  rdat,           32'd0);
        end
        @(posedge clk); #1;

        // Store then load.
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0);

        // Upper address bits wrap; byte offset ignored.
        access(0, 1'b0, 1'b1, 32'h400, 32'h12345678, 1'b0, 1'b0);
        access(0, 1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0);
        access(0, 1'b1, 1'b0, 32'h13,  32'h0,        1'b0, 1'b0);
        access(0, 1'b1, 1'b0, 32'hFFFFFC10, 32'h0,   1'b0, 1'b0);

        // Both requests high: write, data_o unchanged.
        access(0, 1'b1, 1'b1, 32'h20, 32'hAAAA5555, 1'b0, 1'b0);
        access(0, 1'b1, 1'b0, 32'h20, 32'h0,        1'b0, 1'b0);

        // Write dropped in C+1 still commits.
        access(0, 1'b0, 1'b1, 32'h30, 32'h0BADCAFE, 1'b1, 1'b0);
        access(0, 1'b1, 1'b0, 32'h30, 32'h0,        1'b0, 1'b0);

        // Read held through DONE, next accept in the following cycle.
        access(0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b1);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);

        // Reset in C+2 of a store aborts it.
        access(0, 1'b0, 1'b1, 32'h40, 32'h11111111, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D);
        @(negedge clk);
        check("rst_store_stall_c0", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_ack",   {31'd0, ack},   32'd0);
        check("rst_data",  rdat,           32'd0);
        last[0] = 32'h0;
        last[1] = 32'h0;
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("rst_hold_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        access(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0);

        // LATENCY=1 instance.
        access(1, 1'b0, 1'b1, 32'h8, 32'h5A5A1234, 1'b0, 1'b0);
        access(1, 1'b1, 1'b0, 32'h8, 32'h0,        1'b0, 1'b1);
        access(1, 1'b0, 1'b1, 32'hC, 32'h87654321, 1'b0, 1'b0);
        access(1, 1'b1, 1'b0, 32'hC, 32'h0,        1'b0, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        check("sb_empty0", q0.size(), 32'd0);
        check("sb_empty1", q1.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
